// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pe_pkg
// Purpose  : Shared constants, FSM state type and helpers for the PE pixel
//            dispatcher and its result writer.
// Revision : 1.0 - initial release
// ============================================================================
package pe_pkg;

    // Default configuration of the pixel dispatcher
    localparam int DEF_BINARY_OUTPUT_LEVELS = 2;
    localparam int DEF_SYNOPSE_FOLD         = 18;
    localparam int DEF_INPUT_ADDRESS        = 12;
    localparam int DEF_WEIGHT_ADDRESS       = 12;
    localparam int DEF_OUTPUT_ADDRESS       = 12;
    localparam int DEF_NUM_PIXELS           = 16;

    // Layer controller states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_WAIT_RDY = 3'd3,
        ST_DRAIN    = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    // Width of a counter that must be able to hold the value n itself
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_result_writer.sv
`default_nettype none
// ============================================================================
// Module   : pe_result_writer
// Purpose  : Captures PE binary outputs into the activation write port.
//            Counts results, forms base+index write addresses and registers
//            one write per accepted strobe.
// Revision : 1.0 - initial release
// ============================================================================
module pe_result_writer
    import pe_pkg::*;
#(
    parameter int LEVELS     = DEF_BINARY_OUTPUT_LEVELS,
    parameter int OUT_AW     = DEF_OUTPUT_ADDRESS,
    parameter int NUM_PIXELS = DEF_NUM_PIXELS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              capture_en_i,
    input  logic [OUT_AW-1:0] base_addr_i,
    input  logic              valid_i,
    input  logic [LEVELS-1:0] data_i,
    output logic              we_o,
    output logic [OUT_AW-1:0] addr_o,
    output logic [LEVELS-1:0] data_o,
    output logic              all_done_o
);

    localparam int               CNT_W          = cnt_width(NUM_PIXELS);
    localparam logic [CNT_W-1:0] c_num_pixels   = CNT_W'(NUM_PIXELS);

    logic [CNT_W-1:0]  result_idx_q, result_idx_d;
    logic [OUT_AW-1:0] base_q, base_d;
    logic              we_q, we_d;
    logic [OUT_AW-1:0] addr_q, addr_d;
    logic [LEVELS-1:0] data_q, data_d;
    logic              w_accept;

    // Strobes beyond the last expected result are dropped
    assign w_accept   = capture_en_i && valid_i && (result_idx_q < c_num_pixels);
    assign all_done_o = (result_idx_q == c_num_pixels);

    // Next-state: a new layer clears the count, an accepted strobe schedules a write
    always_comb begin
        result_idx_d = result_idx_q;
        base_d       = base_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;
        if (clear_i) begin
            result_idx_d = '0;
            base_d       = base_addr_i;
        end else if (w_accept) begin
            we_d         = 1'b1;
            addr_d       = base_q + OUT_AW'(result_idx_q);
            data_d       = data_i;
            result_idx_d = result_idx_q + CNT_W'(1);
        end
    end

    // Write-port and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_idx_q <= '0;
            base_q       <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
        end else begin
            result_idx_q <= result_idx_d;
            base_q       <= base_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
        end
    end

    assign we_o   = we_q;
    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/pe_pixel_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : pe_pixel_dispatcher
// Purpose  : Layer controller for the PE pixel input. Issues one pixel pulse
//            per PE ready/ack handshake, supplies per-pixel input/weight
//            addresses, collects results and pulses done per layer.
// Revision : 1.0 - initial release
// ============================================================================
module pe_pixel_dispatcher
    import pe_pkg::*;
#(
    parameter int BINARY_OUTPUT_LEVELS = DEF_BINARY_OUTPUT_LEVELS,
    parameter int SYNOPSE_FOLD         = DEF_SYNOPSE_FOLD,
    parameter int INPUT_ADDRESS        = DEF_INPUT_ADDRESS,
    parameter int WEIGHT_ADDRESS       = DEF_WEIGHT_ADDRESS,
    parameter int OUTPUT_ADDRESS       = DEF_OUTPUT_ADDRESS,
    parameter int NUM_PIXELS           = DEF_NUM_PIXELS
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start_i,
    input  logic [INPUT_ADDRESS-1:0]        baseInputAddress_i,
    input  logic [WEIGHT_ADDRESS-1:0]       baseWeightAddress_i,
    input  logic [OUTPUT_ADDRESS-1:0]       baseOutputAddress_i,
    input  logic                            nextPixelCanCome_i,
    input  logic                            peOutValid_i,
    input  logic [BINARY_OUTPUT_LEVELS-1:0] outputPixelOneBit_i,
    output logic                            isPixelIn_o,
    output logic [INPUT_ADDRESS-1:0]        firstInputAddress_o,
    output logic [WEIGHT_ADDRESS-1:0]       firstWeightAddress_o,
    output logic                            outWe_o,
    output logic [OUTPUT_ADDRESS-1:0]       outAddr_o,
    output logic [BINARY_OUTPUT_LEVELS-1:0] outData_o,
    output logic                            busy_o,
    output logic                            done_o
);

    localparam int                       CNT_W        = cnt_width(NUM_PIXELS);
    localparam logic [CNT_W-1:0]         c_last_idx   = CNT_W'(NUM_PIXELS - 1);
    localparam logic [INPUT_ADDRESS-1:0] c_fold       = INPUT_ADDRESS'(SYNOPSE_FOLD);

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            issue_idx_q, issue_idx_d;
    logic [INPUT_ADDRESS-1:0]    in_addr_q, in_addr_d;
    logic [WEIGHT_ADDRESS-1:0]   wt_addr_q, wt_addr_d;
    logic                        w_start_accept;
    logic                        w_acked;
    logic                        w_last_issue;
    logic                        w_results_done;

    assign w_start_accept = (state_q == ST_IDLE) && start_i;
    // PE dropping ready after a pulse is the acceptance of that pixel
    assign w_acked        = (state_q == ST_WAIT_ACK) && !nextPixelCanCome_i;
    assign w_last_issue   = (issue_idx_q == c_last_idx);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: issue / ack / ready handshake per pixel, then drain results
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start_i)             state_d = ST_ISSUE;
            ST_ISSUE:    if (nextPixelCanCome_i)  state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: if (!nextPixelCanCome_i) state_d = w_last_issue ? ST_DRAIN : ST_WAIT_RDY;
            ST_WAIT_RDY: if (nextPixelCanCome_i)  state_d = ST_ISSUE;
            ST_DRAIN:    if (w_results_done)      state_d = ST_DONE;
            ST_DONE:                              state_d = ST_IDLE;
            default:                              state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: the pixel pulse fires in ISSUE as soon as the PE is ready
    always_comb begin
        isPixelIn_o = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            ST_ISSUE: begin
                isPixelIn_o = nextPixelCanCome_i;
                busy_o      = 1'b1;
            end
            ST_WAIT_ACK, ST_WAIT_RDY, ST_DRAIN: busy_o = 1'b1;
            ST_DONE:                            done_o = 1'b1;
            default:                            ;
        endcase
    end

    // Address accumulator: advances by one fold when heading back into ISSUE,
    // so the address is already stable in the cycle the pulse fires
    always_comb begin
        issue_idx_d = issue_idx_q;
        in_addr_d   = in_addr_q;
        wt_addr_d   = wt_addr_q;
        if (w_start_accept) begin
            issue_idx_d = '0;
            in_addr_d   = baseInputAddress_i;
            wt_addr_d   = baseWeightAddress_i;
        end else if (w_acked) begin
            issue_idx_d = issue_idx_q + CNT_W'(1);
        end else if ((state_q == ST_WAIT_RDY) && nextPixelCanCome_i) begin
            in_addr_d   = in_addr_q + c_fold;
        end
    end

    // Issue counter and address registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_idx_q <= '0;
            in_addr_q   <= '0;
            wt_addr_q   <= '0;
        end else begin
            issue_idx_q <= issue_idx_d;
            in_addr_q   <= in_addr_d;
            wt_addr_q   <= wt_addr_d;
        end
    end

    assign firstInputAddress_o  = in_addr_q;
    assign firstWeightAddress_o = wt_addr_q;

    pe_result_writer #(
        .LEVELS     (BINARY_OUTPUT_LEVELS),
        .OUT_AW     (OUTPUT_ADDRESS),
        .NUM_PIXELS (NUM_PIXELS)
    ) u_result_writer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (w_start_accept),
        .capture_en_i (busy_o),
        .base_addr_i  (baseOutputAddress_i),
        .valid_i      (peOutValid_i),
        .data_i       (outputPixelOneBit_i),
        .we_o         (outWe_o),
        .addr_o       (outAddr_o),
        .data_o       (outData_o),
        .all_done_o   (w_results_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_pe_pixel_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_pixel_dispatcher
// Purpose  : Self-checking bench for pe_pixel_dispatcher. A PE stand-in drives
//            ready/ack and result strobes; an event-level reference model
//            predicts pulses, addresses, writes, busy and done each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_pixel_dispatcher;

    localparam int N    = 4;
    localparam int FOLD = 18;
    localparam int AW   = 12;
    localparam int LV   = 2;

    typedef struct {
        logic [AW-1:0]           bin;
        logic [AW-1:0]           bw;
        logic [AW-1:0]           bo;
        int                      dly;
        int                      lat;
        int                      hold;
        logic [0:N-1][LV-1:0]    data;
        logic [0:N-1][AW-1:0]    addr;
    } vec_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          start_i = 1'b0;
    logic [AW-1:0] base_in_i = '0, base_w_i = '0, base_out_i = '0;
    logic          ready_i = 1'b0, pe_valid_i = 1'b0;
    logic [LV-1:0] pe_bits_i = '0;
    logic          isPixelIn_o, outWe_o, busy_o, done_o;
    logic [AW-1:0] fia_o, fwa_o, outAddr_o;
    logic [LV-1:0] outData_o;

    pe_pixel_dispatcher #(
        .BINARY_OUTPUT_LEVELS (LV),
        .SYNOPSE_FOLD         (FOLD),
        .INPUT_ADDRESS        (AW),
        .WEIGHT_ADDRESS       (AW),
        .OUTPUT_ADDRESS       (AW),
        .NUM_PIXELS           (N)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start_i              (start_i),
        .baseInputAddress_i   (base_in_i),
        .baseWeightAddress_i  (base_w_i),
        .baseOutputAddress_i  (base_out_i),
        .nextPixelCanCome_i   (ready_i),
        .peOutValid_i         (pe_valid_i),
        .outputPixelOneBit_i  (pe_bits_i),
        .isPixelIn_o          (isPixelIn_o),
        .firstInputAddress_o  (fia_o),
        .firstWeightAddress_o (fwa_o),
        .outWe_o              (outWe_o),
        .outAddr_o            (outAddr_o),
        .outData_o            (outData_o),
        .busy_o               (busy_o),
        .done_o               (done_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state (event level: counts, cycle stamps, queues)
    bit                   m_busy;
    int                   m_done_at, issued, acked, results;
    bit                   need_low, need_high;
    int                   low_from, high_from, elig_from;
    int                   last_ack, last_write;
    bit                   we_next;
    logic [AW-1:0]        we_addr_next;
    logic [LV-1:0]        we_data_next;
    logic [AW-1:0]        cfg_base_w, cfg_base_out;
    logic [0:N-1][AW-1:0] exp_addr;
    logic [0:N-1][LV-1:0] data_tab;
    bit                   use_formula, noise;

    // PE stand-in state
    int                   ready_back_at, hold_until, delay_fixed, lat_fixed;
    int                   sched_t[$];
    logic [LV-1:0]        sched_d[$];

    vec_t tab [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_isPixelIn"}, 32'(isPixelIn_o), 0);
        check({tag, "_firstInputAddress"}, 32'(fia_o), 0);
        check({tag, "_firstWeightAddress"}, 32'(fwa_o), 0);
        check({tag, "_outWe"}, 32'(outWe_o), 0);
        check({tag, "_outAddr"}, 32'(outAddr_o), 0);
        check({tag, "_outData"}, 32'(outData_o), 0);
        check({tag, "_busy"}, 32'(busy_o), 0);
        check({tag, "_done"}, 32'(done_o), 0);
    endtask

    task automatic model_reset();
        m_busy = 0; m_done_at = -1; issued = 0; acked = 0; results = 0;
        need_low = 0; need_high = 0; low_from = 0; high_from = 0; elig_from = 0;
        last_ack = -1; last_write = -1; we_next = 0;
        ready_back_at = 0; hold_until = 0;
        sched_t.delete(); sched_d.delete();
    endtask

    // One clock cycle: drive PE-side inputs, compare outputs, advance the model
    task automatic cycle(input bit want_start);
        bit            exp_pulse, exp_we, exp_done, acc;
        logic [AW-1:0] ewa;
        logic [LV-1:0] ewd;
        int            tt, idx;
        @(posedge clk);
        #1;
        cyc++;
        if (cyc == m_done_at) m_busy = 0;
        ready_i    = (cyc >= ready_back_at) && (cyc >= hold_until);
        pe_valid_i = 1'b0;
        pe_bits_i  = LV'($urandom);
        if (sched_t.size() > 0 && sched_t[0] == cyc) begin
            pe_valid_i = 1'b1;
            pe_bits_i  = sched_d[0];
            void'(sched_t.pop_front());
            void'(sched_d.pop_front());
        end else if (noise && (!m_busy || results >= N) && $urandom_range(0, 2) == 0) begin
            pe_valid_i = 1'b1;
        end
        start_i = want_start || (noise && (m_busy || cyc == m_done_at) && $urandom_range(0, 3) == 0);
        if (noise && m_busy) begin
            base_in_i = AW'($urandom); base_w_i = AW'($urandom); base_out_i = AW'($urandom);
        end
        #1;
        exp_done  = (cyc == m_done_at);
        exp_pulse = m_busy && issued < N && !need_low && !need_high && cyc >= elig_from && ready_i;
        exp_we    = we_next; ewa = we_addr_next; ewd = we_data_next; we_next = 0;

        check("isPixelIn", 32'(isPixelIn_o), 32'(exp_pulse));
        if (exp_pulse) begin
            check("firstInputAddress", 32'(fia_o), 32'(exp_addr[issued]));
            check("firstWeightAddress", 32'(fwa_o), 32'(cfg_base_w));
        end
        check("outWe", 32'(outWe_o), 32'(exp_we));
        if (exp_we) begin
            check("outAddr", 32'(outAddr_o), 32'(ewa));
            check("outData", 32'(outData_o), 32'(ewd));
        end
        check("busy", 32'(busy_o), 32'(m_busy));
        check("done", 32'(done_o), 32'(exp_done));

        acc = m_busy && results < N && pe_valid_i;
        if (acc) begin
            we_next      = 1;
            we_addr_next = AW'(int'(cfg_base_out) + results);
            we_data_next = pe_bits_i;
            results++;
            if (results == N) last_write = cyc + 1;
        end
        if (exp_pulse) begin
            idx = issued;
            issued++;
            need_low = 1; low_from = cyc + 1;
            ready_back_at = cyc + (delay_fixed > 0 ? delay_fixed : int'($urandom_range(2, 6)));
            tt = cyc + (lat_fixed > 0 ? lat_fixed : int'($urandom_range(1, 9)));
            if (sched_t.size() > 0 && tt <= sched_t[$]) tt = sched_t[$] + 1;
            sched_t.push_back(tt);
            sched_d.push_back(data_tab[idx]);
        end else if (need_low && cyc >= low_from && !ready_i) begin
            need_low = 0;
            acked++;
            if (acked == N) last_ack = cyc;
            else begin need_high = 1; high_from = cyc + 1; end
        end else if (need_high && cyc >= high_from && ready_i) begin
            need_high = 0; elig_from = cyc + 1;
        end
        if (m_busy && m_done_at < 0 && last_ack >= 0 && last_write >= 0)
            m_done_at = ((last_ack + 1 > last_write) ? last_ack + 1 : last_write) + 1;
        if (!m_busy && cyc != m_done_at && start_i) begin
            m_busy = 1; issued = 0; acked = 0; results = 0;
            need_low = 0; need_high = 0; elig_from = cyc + 1;
            last_ack = -1; last_write = -1; m_done_at = -1;
            cfg_base_w = base_w_i; cfg_base_out = base_out_i;
            if (use_formula)
                for (int i = 0; i < N; i++) exp_addr[i] = AW'(int'(base_in_i) + i * FOLD);
            sched_t.delete(); sched_d.delete();
        end
    endtask

    // Run one layer from IDLE; abort_at > 0 stops after that many pulses
    task automatic run_layer(input logic [AW-1:0] bi, input logic [AW-1:0] bw, input logic [AW-1:0] bo,
                             input int dly, input int lat, input int hold, input int abort_at);
        base_in_i = bi; base_w_i = bw; base_out_i = bo;
        delay_fixed = dly; lat_fixed = lat;
        hold_until = cyc + 2 + hold;
        cycle(1'b1);
        for (int k = 0; k < 600; k++) begin
            if (abort_at > 0 && issued >= abort_at) return;
            if (m_done_at >= 0 && cyc > m_done_at) return;
            cycle(1'b0);
        end
        n_vec++; n_err++;
        $display("FAIL layer_timeout at cycle %0d: got no completion, required done at cycle %0d", cyc, m_done_at);
    endtask

    initial begin
        tab[0] = '{bin:12'd0,    bw:12'd0,    bo:12'd100,  dly:5, lat:3, hold:0,
                   data:{2'b01, 2'b11, 2'b00, 2'b10}, addr:{12'd0, 12'd18, 12'd36, 12'd54}};
        tab[1] = '{bin:12'd4090, bw:12'h0AB,  bo:12'd4094, dly:3, lat:2, hold:0,
                   data:{2'b10, 2'b01, 2'b11, 2'b00}, addr:{12'd4090, 12'd12, 12'd30, 12'd48}};
        tab[2] = '{bin:12'd100,  bw:12'd7,    bo:12'd0,    dly:2, lat:6, hold:50,
                   data:{2'b11, 2'b11, 2'b01, 2'b00}, addr:{12'd100, 12'd118, 12'd136, 12'd154}};
        tab[3] = '{bin:12'd4095, bw:12'd4095, bo:12'd4095, dly:4, lat:1, hold:0,
                   data:{2'b00, 2'b01, 2'b10, 2'b11}, addr:{12'd4095, 12'd17, 12'd35, 12'd53}};
        model_reset();
        noise = 0; use_formula = 0; delay_fixed = 0; lat_fixed = 0;

        // Power-on reset state
        #1 rst_n = 1'b0;
        #1 check_zero("reset");
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // Stray strobes while idle must not write
        noise = 1;
        repeat (8) cycle(1'b0);
        noise = 0;

        // Table-driven layers
        for (int v = 0; v < 4; v++) begin
            exp_addr = tab[v].addr; data_tab = tab[v].data; use_formula = 0;
            run_layer(tab[v].bin, tab[v].bw, tab[v].bo, tab[v].dly, tab[v].lat, tab[v].hold, 0);
        end

        // Abort mid-layer after two pulses, then a clean restart from pixel 0
        exp_addr = tab[0].addr; data_tab = tab[0].data; use_formula = 0;
        run_layer(tab[0].bin, tab[0].bw, tab[0].bo, tab[0].dly, tab[0].lat, 0, 2);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_zero("abort");
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        model_reset();
        run_layer(tab[0].bin, tab[0].bw, tab[0].bo, tab[0].dly, tab[0].lat, 0, 0);

        // Randomized layers with ignored starts, base changes and extra strobes
        use_formula = 1;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) data_tab[i] = LV'($urandom);
            noise = 0;
            cycle(1'b0);
            noise = 1;
            run_layer(AW'($urandom), AW'($urandom), AW'($urandom), 0, 0, int'($urandom_range(0, 5)), 0);
            repeat (3) cycle(1'b0);
        end
        noise = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pe_pixel_dispatcher.md
Name: pe_pixel_dispatcher

Overview:
Layer-level controller that drives the pixel-input side of the processing element (PEDesign) and collects its results.
- Per layer, issues num_pixels pixels to the PE, one isPixelIn pulse per pixel, paced by the PE's nextPixelCanCome.
- Supplies per-pixel first input and weight addresses.
- Captures each multi-level binary output into the activation write port.
- Pulses done when the layer is complete.

Parameters:
binary_output_levels, 2, residual binary levels per PE output
synopseFold, 18, input-memory words consumed per pixel (address stride)
input_address, 12, input memory address width
weight_address, 12, weight memory address width
output_address, 12, activation write address width
num_pixels, 16, pixels per layer (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-low reset
start  in  1  layer start pulse, accepted only in IDLE
baseInputAddress  in  input_address  input address of pixel 0, sampled on accepted start
baseWeightAddress  in  weight_address  weight address for every pixel, sampled on accepted start
baseOutputAddress  in  output_address  write address of result 0, sampled on accepted start
nextPixelCanCome  in  1  PE ready for a new pixel
peOutValid  in  1  one-cycle strobe, outputPixelOneBit valid
outputPixelOneBit  in  binary_output_levels  PE binary output
isPixelIn  out  1  pixel-issue pulse to PE
firstInputAddress  out  input_address  pixel start address to PE
firstWeightAddress  out  weight_address  weight start address to PE
outWe  out  1  activation write enable
outAddr  out  output_address  activation write address
outData  out  binary_output_levels  activation write data
busy  out  1  high from accepted start until done
done  out  1  one-cycle layer-complete pulse

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs 0; state IDLE; counters 0.
  - Reset mid-layer aborts immediately. No pending write completes; done does not pulse.
- States: IDLE, ISSUE, WAIT_ACK, WAIT_RDY, DRAIN, DONE.
- IDLE: on start=1, latch the three bases, clear issue and result counters, set busy, go to ISSUE.
- ISSUE:
  - When nextPixelCanCome=1, assert isPixelIn for exactly one cycle, then go to WAIT_ACK.
  - In that same cycle, firstInputAddress = base_in + issue_idx*synopseFold, truncated modulo 2^input_address (wrap allowed).
  - firstWeightAddress = base_weight.
  - Both address outputs are registered and held stable until the next issue.
  - If nextPixelCanCome=0, wait in ISSUE.
- WAIT_ACK: wait for nextPixelCanCome=0, which confirms the PE accepted the pixel.
  - Then increment issue_idx.
  - If issue_idx = num_pixels, go to DRAIN; else go to WAIT_RDY.
- WAIT_RDY: when nextPixelCanCome=1, go to ISSUE. Minimum spacing between isPixelIn pulses is 3 cycles.
- Result capture (any state except IDLE/DONE):
  - On peOutValid=1, the next cycle has outWe=1, outData=outputPixelOneBit, outAddr = base_out + result_idx (mod 2^output_address).
  - result_idx then increments.
  - peOutValid coinciding with isPixelIn, or with any state transition, is always captured.
  - peOutValid once result_idx = num_pixels is ignored.
- DRAIN: wait until result_idx = num_pixels, including the final write cycle, then go to DONE.
- DONE: done=1 for one cycle, busy cleared, return to IDLE.
- start while busy=1 is ignored; start in the DONE cycle is ignored.
- peOutValid in IDLE is ignored (no outWe).
- num_pixels=1: one issue, one write, done.
- Counter width: $clog2(num_pixels+1).
- Multiplier-free: the input address is an accumulator, adding synopseFold per issue.

Decomposition:
- Shared package pe_pkg: state enum, address-width constants, levels constant.
- One natural sub-module, pe_result_writer: result counter, address add, write register.
- FSM and address accumulator stay in the top module.

Test Plan:
1. Reset with rst=0 mid-layer (after 2 issues) -> all outputs 0 within the same cycle; a new start restarts from pixel 0 at baseInputAddress.
2. num_pixels=4, baseIn=0, PE model ready again 5 cycles after each pulse -> isPixelIn pulses with firstInputAddress 0, 18, 36, 54; firstWeightAddress constant 0.
3. Results 2'b01, 2'b11, 2'b00, 2'b10 with baseOut=100 -> outWe writes at 100, 101, 102, 103 with matching data; done one cycle after the last write; busy falls with done.
4. Address wrap: baseIn=4090, synopseFold=18 -> second pixel firstInputAddress = 12.
5. nextPixelCanCome held 0 for 50 cycles after start -> no isPixelIn, busy=1. Assert it -> one pulse exactly.
6. start pulsed during a layer, and peOutValid in IDLE -> no restart, no outWe; extra peOutValid after 4 results -> ignored.
